// File: rtl/hw_thread_scheduler.sv
// Coarse-grained multithreading controller: owns per-thread saved PCs and
// swaps the fetch PC to the next runnable thread on quantum expiry, yield or halt.
module hw_thread_scheduler #(
    parameter int          NUM_THREADS      = 2,
    parameter int          TID_W            = 2,
    parameter int          QUANTUM          = 1024,
    parameter logic [31:0] RESET_PC         = 32'h1eceb000,
    parameter logic [31:0] THREAD_PC_STRIDE = 32'h0000_1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   core_stall,
    input  logic                   yield_req,
    input  logic                   halt_req,
    input  logic                   mem_idle,
    input  logic [31:0]            resume_pc,
    output logic                   sched_hold,
    output logic                   swap_pc,
    output logic [31:0]            swap_target_pc,
    output logic [TID_W-1:0]       active_tid,
    output logic [NUM_THREADS-1:0] runnable,
    output logic                   all_halted
);

    localparam int SLOTS = 1 << TID_W;
    localparam int CNT_W = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
    localparam logic [CNT_W-1:0] QMAX = CNT_W'(QUANTUM - 1);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_SWAP   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    logic [1:0]       state;
    logic [TID_W-1:0] next_tid;
    logic [CNT_W-1:0] qcount;
    // Sized to the full tid space so any tid indexes it without range games.
    logic [31:0]      saved_pc [SLOTS];

    logic             quantum_hit;
    logic             trigger;
    logic             other_found;
    logic [TID_W-1:0] pick_tid;
    logic [SLOTS-1:0] runnable_ext;
    logic [NUM_THREADS-1:0] active_mask;

    assign quantum_hit  = !core_stall && (qcount == QMAX);
    assign trigger      = quantum_hit || yield_req || halt_req;
    assign runnable_ext = SLOTS'(runnable);
    assign active_mask  = NUM_THREADS'(1) << active_tid;

    assign sched_hold = (state != ST_RUN);
    assign swap_pc    = (state == ST_SWAP);
    assign all_halted = (state == ST_HALTED);

    // Round-robin scan starting just after the active thread, never picking it.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        other_found = 1'b0;
        pick_tid    = '0;
        for (int k = 1; k < NUM_THREADS; k++) begin
            int idx;
            idx = int'(active_tid) + k;
            if (idx >= NUM_THREADS) idx = idx - NUM_THREADS;
            if (!other_found && runnable_ext[TID_W'(idx)]) begin
                other_found = 1'b1;
                pick_tid    = TID_W'(idx);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_RUN;
            active_tid     <= '0;
            next_tid       <= '0;
            runnable       <= '1;
            qcount         <= '0;
            swap_target_pc <= '0;
            // NOTE: the saved-PC file is reset on purpose; each thread needs a defined start PC.
            for (int i = 0; i < SLOTS; i++) begin
                saved_pc[i] <= RESET_PC + 32'(i) * THREAD_PC_STRIDE;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (trigger) begin
                        if (halt_req) runnable <= runnable & ~active_mask;
                        if (!other_found) begin
                            if (halt_req) state <= ST_HALTED;
                            else          qcount <= '0;
                        end else begin
                            next_tid <= pick_tid;
                            state    <= ST_DRAIN;
                        end
                    end else if (!core_stall) begin
                        qcount <= qcount + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (mem_idle) begin
                        saved_pc[active_tid] <= resume_pc;
                        swap_target_pc       <= saved_pc[next_tid];
                        state                <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    active_tid <= next_tid;
                    qcount     <= '0;
                    state      <= ST_RUN;
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hw_thread_scheduler.sv
// Bench for hw_thread_scheduler: a directed table, hand-written corner sequences
// and random stimulus, all compared every cycle against a behavioural model.
module tb_hw_thread_scheduler;

    localparam int          NT     = 3;
    localparam int          TW     = 2;
    localparam int          Q      = 40;
    localparam logic [31:0] RPC    = 32'h1eceb000;
    localparam logic [31:0] STRIDE = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          rst, core_stall, yield_req, halt_req, mem_idle;
    logic [31:0]   resume_pc;
    logic          sched_hold, swap_pc, all_halted;
    logic [31:0]   swap_target_pc;
    logic [TW-1:0] active_tid;
    logic [NT-1:0] runnable;

    always #5 clk = ~clk;

    hw_thread_scheduler #(
        .NUM_THREADS(NT), .TID_W(TW), .QUANTUM(Q),
        .RESET_PC(RPC), .THREAD_PC_STRIDE(STRIDE)
    ) dut (
        .clk(clk), .rst(rst), .core_stall(core_stall), .yield_req(yield_req),
        .halt_req(halt_req), .mem_idle(mem_idle), .resume_pc(resume_pc),
        .sched_hold(sched_hold), .swap_pc(swap_pc), .swap_target_pc(swap_target_pc),
        .active_tid(active_tid), .runnable(runnable), .all_halted(all_halted)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model, stepped once per rising edge with the applied inputs.
    typedef enum int {P_RUN, P_DRAIN, P_SWAP, P_HALTED} phase_t;
    phase_t      m_phase;
    bit          m_run [NT];
    logic [31:0] m_saved [NT];
    logic [31:0] m_last_target;
    int          m_active, m_next, m_count;

    logic          obs_hold, obs_swap, obs_halted;
    logic [31:0]   obs_tgt;
    logic [TW-1:0] obs_tid;
    logic [NT-1:0] obs_run;

    function automatic int m_pick();
        for (int k = 1; k < NT; k++) begin
            if (m_run[(m_active + k) % NT]) return (m_active + k) % NT;
        end
        return -1;
    endfunction

    task automatic model_step();
        int nxt;
        if (rst) begin
            m_phase = P_RUN; m_active = 0; m_next = 0; m_count = 0; m_last_target = 32'h0;
            for (int i = 0; i < NT; i++) begin
                m_run[i]   = 1'b1;
                m_saved[i] = RPC + 32'(i) * STRIDE;
            end
        end else begin
            case (m_phase)
                P_RUN: begin
                    if (halt_req || yield_req || (!core_stall && m_count == Q - 1)) begin
                        if (halt_req) m_run[m_active] = 1'b0;
                        nxt = m_pick();
                        if (nxt < 0) begin
                            if (halt_req) m_phase = P_HALTED;
                            else          m_count = 0;
                        end else begin
                            m_next  = nxt;
                            m_phase = P_DRAIN;
                        end
                    end else if (!core_stall) begin
                        m_count++;
                    end
                end
                P_DRAIN: begin
                    if (mem_idle) begin
                        m_saved[m_active] = resume_pc;
                        m_phase = P_SWAP;
                    end
                end
                P_SWAP: begin
                    m_last_target = m_saved[m_next];
                    m_active = m_next;
                    m_count  = 0;
                    m_phase  = P_RUN;
                end
                default: ;
            endcase
        end
    endtask

    // Compare all outputs against the model on the falling edge, then clock.
    task automatic tick(input string tag);
        logic          e_hold, e_swap, e_halted;
        logic [31:0]   e_tgt;
        logic [TW-1:0] e_tid;
        logic [NT-1:0] e_run;
        @(negedge clk);
        e_hold   = (m_phase != P_RUN);
        e_swap   = (m_phase == P_SWAP);
        e_halted = (m_phase == P_HALTED);
        e_tgt    = (m_phase == P_SWAP) ? m_saved[m_next] : m_last_target;
        e_tid    = TW'(m_active);
        for (int i = 0; i < NT; i++) e_run[i] = m_run[i];
        obs_hold = sched_hold; obs_swap = swap_pc; obs_halted = all_halted;
        obs_tgt  = swap_target_pc; obs_tid = active_tid; obs_run = runnable;
        n_vec++;
        if ({obs_hold, obs_swap, obs_halted, obs_tgt, obs_tid, obs_run} !==
            {e_hold, e_swap, e_halted, e_tgt, e_tid, e_run}) begin
            n_err++;
            $display("FAIL %s t=%0t: got hold=%b swap=%b tgt=%h tid=%0d run=%b halted=%b, want hold=%b swap=%b tgt=%h tid=%0d run=%b halted=%b",
                     tag, $time, obs_hold, obs_swap, obs_tgt, obs_tid, obs_run, obs_halted,
                     e_hold, e_swap, e_tgt, e_tid, e_run, e_halted);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit s, input bit y, input bit h, input bit i, input logic [31:0] pc);
        core_stall = s; yield_req = y; halt_req = h; mem_idle = i; resume_pc = pc;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(0, 0, 0, 1, resume_pc);
        tick("reset");
        rst = 1'b0;
    endtask

    task automatic run_quiet(input int n, output int swaps);
        swaps = 0;
        for (int c = 0; c < n; c++) begin
            drive(0, 0, 0, 1, resume_pc);
            tick("quiet");
            if (obs_swap) swaps++;
        end
    endtask

    // Bounded wait for a swap pulse; 'at' is the tick index, or -1 if none came.
    task automatic wait_swap(input int budget, output int at);
        at = -1;
        for (int c = 0; c < budget; c++) begin
            tick("wait_swap");
            if (obs_swap) begin
                at = c;
                break;
            end
        end
        if (at < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_swap: got no swap_pc within %0d cycles, want one", budget);
        end
    endtask

    typedef struct {
        bit          rst, stall, yield, halt, idle;
        logic [31:0] rpc;
        bit          hold, swap;
        logic [31:0] tgt;
        logic [TW-1:0] tid;
        logic [NT-1:0] run;
        bit          halted;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int at, sw;
        // Yield with a memory drain, then round-robin through all three threads.
        tbl[0]  = '{0,0,0,0,1, 32'h0,        0,0, 32'h0,        2'd0, 3'b111, 0};
        tbl[1]  = '{0,0,1,0,1, 32'h0,        0,0, 32'h0,        2'd0, 3'b111, 0};
        tbl[2]  = '{0,0,0,0,0, 32'h0,        1,0, 32'h0,        2'd0, 3'b111, 0};
        tbl[3]  = '{0,0,0,0,0, 32'h0,        1,0, 32'h0,        2'd0, 3'b111, 0};
        tbl[4]  = '{0,0,0,0,1, 32'h1eceb028, 1,0, 32'h0,        2'd0, 3'b111, 0};
        tbl[5]  = '{0,0,0,0,1, 32'h0,        1,1, 32'h1ecec000, 2'd0, 3'b111, 0};
        tbl[6]  = '{0,0,0,0,1, 32'h0,        0,0, 32'h1ecec000, 2'd1, 3'b111, 0};
        tbl[7]  = '{0,0,1,0,1, 32'h0,        0,0, 32'h1ecec000, 2'd1, 3'b111, 0};
        tbl[8]  = '{0,0,1,1,0, 32'h0,        1,0, 32'h1ecec000, 2'd1, 3'b111, 0};
        tbl[9]  = '{0,0,0,0,1, 32'h1ecec0a0, 1,0, 32'h1ecec000, 2'd1, 3'b111, 0};
        tbl[10] = '{0,0,0,0,1, 32'h0,        1,1, 32'h1eced000, 2'd1, 3'b111, 0};
        tbl[11] = '{0,0,1,0,1, 32'h0,        0,0, 32'h1eced000, 2'd2, 3'b111, 0};
        tbl[12] = '{0,0,0,0,1, 32'h1eced0f0, 1,0, 32'h1eced000, 2'd2, 3'b111, 0};
        tbl[13] = '{0,0,0,0,1, 32'h0,        1,1, 32'h1eceb028, 2'd2, 3'b111, 0};
        tbl[14] = '{0,0,0,0,1, 32'h0,        0,0, 32'h1eceb028, 2'd0, 3'b111, 0};

        rst = 1'b1;
        drive(0, 0, 0, 1, 32'h0);
        @(posedge clk);
        model_step();
        #1;
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].rst;
            drive(tbl[i].stall, tbl[i].yield, tbl[i].halt, tbl[i].idle, tbl[i].rpc);
            tick("table");
            check($sformatf("table[%0d]", i),
                  {24'h0, obs_hold, obs_swap, obs_halted, obs_tgt, obs_tid, obs_run},
                  {24'h0, tbl[i].hold, tbl[i].swap, tbl[i].halted, tbl[i].tgt, tbl[i].tid, tbl[i].run});
        end

        // Quantum expiry: swap at tick Q+1 after reset, and saved PCs round-trip.
        apply_reset();
        drive(0, 0, 0, 1, 32'h1eceb444);
        wait_swap(Q + 10, at);
        check("quantum_swap_cycle", 64'(at), 64'(Q + 1));
        check("quantum_swap_target", {32'h0, obs_tgt}, {32'h0, 32'h1ecec000});
        drive(0, 0, 0, 1, 32'h1ecec555);
        wait_swap(Q + 10, at);
        check("quantum_swap2_target", {32'h0, obs_tgt}, {32'h0, 32'h1eced000});
        wait_swap(Q + 10, at);
        check("quantum_swap3_target", {32'h0, obs_tgt}, {32'h0, 32'h1eceb444});

        // core_stall freezes the counter: 50 stalled cycles shift expiry by exactly 50.
        apply_reset();
        for (int c = 0; c < 50; c++) begin
            drive(1, 0, 0, 1, 32'h0);
            tick("stall");
            check("stall_no_swap", 64'(obs_swap), 64'(0));
        end
        drive(0, 0, 0, 1, 32'h0);
        wait_swap(Q + 10, at);
        check("stall_swap_cycle", 64'(at), 64'(Q + 1));

        // Halt chain down to one thread, then to HALTED.
        apply_reset();
        drive(0, 1, 0, 1, 32'h1eceb100);
        tick("halt_chain");
        drive(0, 0, 0, 1, 32'h1eceb100);
        wait_swap(10, at);
        check("yield_latency", 64'(at), 64'(1));
        drive(0, 0, 1, 1, 32'h1eceb100);
        tick("halt_chain");
        drive(0, 0, 0, 1, 32'h1eceb100);
        wait_swap(10, at);
        check("halt_t1_runnable", 64'(obs_run), 64'(3'b101));
        check("halt_t1_target", {32'h0, obs_tgt}, {32'h0, 32'h1eced000});
        drive(0, 0, 1, 1, 32'h1eceb100);
        tick("halt_chain");
        drive(0, 0, 0, 1, 32'h1eceb100);
        wait_swap(10, at);
        check("halt_t2_runnable", 64'(obs_run), 64'(3'b001));
        check("halt_t2_target", {32'h0, obs_tgt}, {32'h0, 32'h1eceb100});
        run_quiet(2 * Q + 5, sw);
        check("lone_thread_no_swap", 64'(sw), 64'(0));
        check("lone_thread_tid", 64'(obs_tid), 64'(0));
        drive(0, 0, 1, 1, 32'h0);
        tick("halt_chain");
        run_quiet(3, sw);
        check("all_halted", 64'(obs_halted), 64'(1));
        check("halted_hold", 64'(obs_hold), 64'(1));
        sw = 0;
        for (int c = 0; c < 10; c++) begin
            drive(0, c[0], 0, 1, 32'h0);
            tick("halted");
            if (obs_swap) sw++;
        end
        check("halted_no_swap", 64'(sw), 64'(0));

        // Yield, halt and quantum expiry together: one swap, halted bit cleared.
        apply_reset();
        run_quiet(Q - 1, sw);
        drive(0, 1, 1, 1, 32'h0);
        tick("combo");
        run_quiet(12, sw);
        check("combo_swap_count", 64'(sw), 64'(1));
        check("combo_runnable", 64'(obs_run), 64'(3'b110));
        check("combo_tid", 64'(obs_tid), 64'(1));

        // Reset in the middle of a drain abandons it.
        apply_reset();
        drive(0, 1, 0, 0, 32'hdead0000);
        tick("rst_drain");
        drive(0, 0, 0, 0, 32'hdead0000);
        tick("rst_drain");
        apply_reset();
        drive(0, 0, 0, 1, 32'h0);
        tick("rst_drain");
        check("rst_drain_hold", 64'(obs_hold), 64'(0));
        check("rst_drain_swap", 64'(obs_swap), 64'(0));
        check("rst_drain_tid", 64'(obs_tid), 64'(0));
        drive(0, 1, 0, 1, 32'h0);
        tick("rst_drain");
        drive(0, 0, 0, 1, 32'h0);
        wait_swap(10, at);
        check("rst_drain_target", {32'h0, obs_tgt}, {32'h0, 32'h1ecec000});

        // Random stimulus against the model.
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(299) == 0);
            drive($urandom_range(3) == 0, $urandom_range(15) == 0, $urandom_range(39) == 0,
                  $urandom_range(3) != 0, $urandom);
            tick("rand");
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hw_thread_scheduler.md
Name: hw_thread_scheduler

Overview:
- Coarse-grained multithreading controller for the pipelined core.
- Owns the per-hardware-thread saved PCs and decides when the fetch PC is swapped to another thread.
- Drives the PC register's scheduler swap pulse and target PC.
- Swap triggers: quantum expiry, explicit yield, thread halt. A swap is taken only once the memory stage is idle.

Parameters:
- NUM_THREADS, 2: hardware thread count, legal range 2..4.
- TID_W, 2: width of thread-id signals; must satisfy 2^TID_W >= NUM_THREADS.
- QUANTUM, 1024: cycles a thread runs before a forced swap. Counted only in cycles where the core is not stalled.
- RESET_PC, 32'h1eceb000: thread 0 start PC.
- THREAD_PC_STRIDE, 32'h0000_1000: thread i starts at RESET_PC + i*THREAD_PC_STRIDE.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high; clock clk
- core_stall  in  1  pipeline stalled this cycle; freezes the quantum counter
- yield_req  in  1  single-cycle pulse: committed yield instruction from the active thread
- halt_req  in  1  single-cycle pulse: committed halt/ecall-exit from the active thread
- mem_idle  in  1  no outstanding data-memory transaction; required before a swap
- resume_pc  in  32  PC of the oldest uncommitted instruction of the active thread; captured as its saved PC
- sched_hold  out  1  stalls fetch/issue while draining
- swap_pc  out  1  one-cycle pulse into the PC register's swap input; also the pipeline flush
- swap_target_pc  out  32  PC loaded when swap_pc=1
- active_tid  out  TID_W  thread currently owning the pipeline
- runnable  out  NUM_THREADS  per-thread runnable mask
- all_halted  out  1  every thread is halted

Behaviour:
- Reset values:
  - state=RUN, active_tid=0, runnable=all ones, quantum counter=0.
  - saved_pc[i]=RESET_PC+i*THREAD_PC_STRIDE.
  - sched_hold=0, swap_pc=0, swap_target_pc=0, all_halted=0.
- Reset mid-DRAIN or mid-SWAP abandons the operation and returns to the reset values on the next edge.
- States: RUN, DRAIN, SWAP, HALTED.
- RUN:
  - Counter increments when core_stall=0.
  - Trigger when counter==QUANTUM-1 with core_stall=0, or yield_req=1, or halt_req=1.
  - Simultaneous triggers produce a single swap; halt has priority and always clears runnable[active_tid].
  - A halt trigger clears runnable[active_tid] on the trigger edge.
  - Next thread = first runnable thread scanning active_tid+1, +2, ... modulo NUM_THREADS, excluding active_tid.
  - No other runnable thread on a quantum or yield trigger: counter resets to 0, stay in RUN, no swap.
  - No other runnable thread on a halt trigger: go to HALTED.
  - Otherwise latch next_tid and go to DRAIN.
- DRAIN:
  - sched_hold=1 (combinational on state).
  - Further yield_req and halt_req pulses are ignored.
  - When mem_idle=1: saved_pc[active_tid] <= resume_pc (the value is don't-care for a halted thread), go to SWAP. Minimum residency is 1 cycle.
- SWAP:
  - Exactly one cycle with swap_pc=1, swap_target_pc=saved_pc[next_tid], sched_hold=1.
  - On that edge: active_tid <= next_tid, counter <= 0, go to RUN.
  - swap_target_pc outside SWAP holds its last value.
- HALTED:
  - all_halted=1, sched_hold=1, no swap pulses. Only rst exits this state.
- Latency: trigger edge -> DRAIN; with mem_idle already 1, swap_pc asserts 2 cycles after the trigger cycle.
- All PC arithmetic is 32-bit modulo 2^32.
- The quantum counter is wide enough for QUANTUM-1.

Test Plan:
1. Reset, hold core_stall=0, yield/halt=0, mem_idle=1 -> swap_pc pulses once at cycle QUANTUM+2 with swap_target_pc=32'h1ecec000, active_tid becomes 1; the next swap targets the resume_pc captured for thread 0.
2. yield_req pulse at cycle 10 with resume_pc=32'h1eceb028 and mem_idle=0 for cycles 11-14 -> sched_hold=1 cycles 11-15, swap_pc=1 only at cycle 16; the saved_pc[0] readback on the later swap back is 32'h1eceb028.
3. halt_req in thread 1 with thread 0 runnable -> runnable=2'b01, swap to thread 0; afterwards quantum expiry causes no swap and the counter restarts.
4. halt_req in thread 0 with thread 1 already halted -> state HALTED, all_halted=1, sched_hold=1, no further swap_pc.
5. yield_req and halt_req plus quantum expiry in the same cycle -> exactly one swap_pc pulse, runnable bit cleared; core_stall=1 for 50 cycles delays quantum expiry by exactly 50 cycles.
6. rst asserted during DRAIN -> next cycle sched_hold=0, active_tid=0, no swap_pc; the first swap after reset targets 32'h1ecec000.
